// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths and constants for the picoMips accumulator ALU
package alu_pkg;
    localparam int          ACC_W     = 8;
    localparam int          FRAC_BITS = 3;
    localparam logic [7:0]  ONE_Q43   = 8'h08;
endpackage

// File: rtl/mul0mux.sv
// rtl/mul0mux.sv - pass-or-zero gate for the accumulator base term
module mul0mux
    import alu_pkg::*;
(
    input  logic [ACC_W-1:0] In,
    input  logic             En,
    output logic [ACC_W-1:0] Out
);
    assign Out = En ? In : '0;
endmodule

// File: rtl/mul3mux.sv
// rtl/mul3mux.sv - three-way AND-OR operand mux with a force-to-zero input
module mul3mux
    import alu_pkg::*;
(
    input  logic [ACC_W-1:0] A,
    input  logic [ACC_W-1:0] B,
    input  logic [ACC_W-1:0] C,
    input  logic             SA,
    input  logic             SB,
    input  logic             SC,
    input  logic             Z,
    output logic [ACC_W-1:0] Out
);
    logic [ACC_W-1:0] w_or;

    // Multiple selects OR together; Z overrides everything with zero.
    assign w_or = ({ACC_W{SA}} & A) | ({ACC_W{SB}} & B) | ({ACC_W{SC}} & C);
    assign Out  = Z ? '0 : w_or;
endmodule

// File: rtl/mult.sv
// rtl/mult.sv - 8x8 signed multiply keeping the low 8 bits of the product
module mult
    import alu_pkg::*;
(
    input  logic signed [ACC_W-1:0] A,
    input  logic signed [ACC_W-1:0] B,
    output logic signed [ACC_W-1:0] Out
);
    assign Out = A * B;
endmodule

// File: rtl/alu_mac.sv
// rtl/alu_mac.sv - accumulator add / Q4.3 multiply unit with a single ACC register
module alu_mac
    import alu_pkg::*;
(
    input  logic             Clock,
    input  logic             nReset,
    input  logic [ACC_W-1:0] Imm,
    input  logic [ACC_W-1:0] RegData,
    input  logic [ACC_W-1:0] SW,
    input  logic             WE,
    input  logic             SelSW,
    input  logic             SelImm,
    input  logic             SelRegData,
    input  logic             UseMul,
    input  logic             UseACC,
    output logic [ACC_W-1:0] ACC
);
    localparam int P_W = ACC_W + FRAC_BITS;

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_data;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_mult;
    logic [ACC_W-1:0] w_a;
    logic [ACC_W-1:0] w_b;
    logic [P_W-1:0]   w_p;
    logic [ACC_W-1:0] w_next;

    mul3mux u_mul3mux (
        .A   (Imm),
        .B   (SW),
        .C   (RegData),
        .SA  (SelImm),
        .SB  (SelSW),
        .SC  (SelRegData),
        .Z   (UseMul),
        .Out (w_data)
    );

    mul0mux u_mul0mux (
        .In  (r_acc),
        .En  (UseACC),
        .Out (w_base)
    );

    mult u_mult (
        .A   ({{(ACC_W-1){1'b0}}, UseMul}),
        .B   (Imm),
        .Out (w_mult)
    );

    assign w_a = w_base + w_data;
    // In add mode the multiplier becomes 1.0 in Q4.3, so the shift restores the sum.
    assign w_b = w_mult | ({ACC_W{~UseMul}} & ONE_Q43);

    // Only the low P_W product bits matter, so sign-extend and multiply at that width.
    assign w_p    = {{FRAC_BITS{w_a[ACC_W-1]}}, w_a} * {{FRAC_BITS{w_b[ACC_W-1]}}, w_b};
    assign w_next = ACC_W'(w_p >> FRAC_BITS);

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            r_acc <= '0;
        end else if (WE) begin
            r_acc <= w_next;
        end
    end

    assign ACC = r_acc;
endmodule

// File: tb/tb_alu_mac.sv
// tb/tb_alu_mac.sv - self-checking bench for alu_mac against an arithmetic reference model
`timescale 1ns/1ps
module tb_alu_mac;
    logic       Clock = 1'b0;
    logic       nReset;
    logic [7:0] Imm, RegData, SW;
    logic       WE, SelSW, SelImm, SelRegData, UseMul, UseACC;
    logic [7:0] ACC;

    int checks = 0;
    int errors = 0;

    alu_mac dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .Imm        (Imm),
        .RegData    (RegData),
        .SW         (SW),
        .WE         (WE),
        .SelSW      (SelSW),
        .SelImm     (SelImm),
        .SelRegData (SelRegData),
        .UseMul     (UseMul),
        .UseACC     (UseACC),
        .ACC        (ACC)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] model_next(
        input logic [7:0] acc, input logic use_acc, input logic use_mul,
        input logic s_imm, input logic s_sw, input logic s_reg,
        input logic [7:0] imm, input logic [7:0] sw, input logic [7:0] reg_d);
        int base, data, prod, res;
        base = use_acc ? int'($signed(acc)) : 0;
        if (use_mul) begin
            prod = base * int'($signed(imm));
            res  = prod >>> 3;
        end else begin
            data = 0;
            if (s_imm) data = data | int'(imm);
            if (s_sw)  data = data | int'(sw);
            if (s_reg) data = data | int'(reg_d);
            res = base + data;
        end
        return res[7:0];
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        Imm = 8'h00; RegData = 8'h00; SW = 8'h00;
        WE = 1'b0; SelSW = 1'b0; SelImm = 1'b0; SelRegData = 1'b0;
        UseMul = 1'b0; UseACC = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        idle_inputs();
        nReset = 1'b1; UseACC = 1'b0; SelImm = 1'b1; Imm = v; WE = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        nReset = 1'b0; WE = 1'b1;
        step();
        checks++;
        if (ACC !== 8'h00) begin
            errors++; $display("FAIL reset_initial ACC=%02h expected=00", ACC);
        end
        load(8'h5A);
        checks++;
        if (ACC !== 8'h5A) begin
            errors++; $display("FAIL reset_preload ACC=%02h expected=5A", ACC);
        end
        nReset = 1'b0; WE = 1'b1;
        #2;
        checks++;
        if (ACC !== 8'h5A) begin
            errors++; $display("FAIL reset_between_edges ACC=%02h expected=5A", ACC);
        end
        step();
        checks++;
        if (ACC !== 8'h00) begin
            errors++; $display("FAIL reset_priority ACC=%02h expected=00", ACC);
        end
        nReset = 1'b1;
    endtask

    task automatic test_load_hold();
        load(8'h25);
        checks++;
        if (ACC !== 8'h25) begin
            errors++; $display("FAIL load ACC=%02h expected=25", ACC);
        end
        idle_inputs();
        WE = 1'b0; SW = 8'hFF; SelSW = 1'b1; UseACC = 1'b1;
        step();
        checks++;
        if (ACC !== 8'h25) begin
            errors++; $display("FAIL hold ACC=%02h expected=25", ACC);
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] tbl_acc [3];
        logic [7:0] tbl_opd [3];
        logic [7:0] tbl_exp [3];
        tbl_acc = '{8'h25, 8'h7F, 8'hFF};
        tbl_opd = '{8'h10, 8'h01, 8'h02};
        tbl_exp = '{8'h35, 8'h80, 8'h01};
        for (int i = 0; i < 3; i++) begin
            load(tbl_acc[i]);
            idle_inputs();
            WE = 1'b1; UseACC = 1'b1;
            if (i == 0) begin SelSW = 1'b1; SW = tbl_opd[i]; end
            else        begin SelRegData = 1'b1; RegData = tbl_opd[i]; end
            step();
            checks++;
            if (ACC !== tbl_exp[i]) begin
                errors++;
                $display("FAIL accumulate[%0d] ACC=%02h expected=%02h", i, ACC, tbl_exp[i]);
            end
        end
    endtask

    task automatic run_mul(input string name, input logic [7:0] acc0, input logic [7:0] imm,
                           input logic sel_imm, input logic [7:0] expv);
        load(acc0);
        idle_inputs();
        WE = 1'b1; UseACC = 1'b1; UseMul = 1'b1; Imm = imm; SelImm = sel_imm;
        step();
        checks++;
        if (ACC !== expv) begin
            errors++; $display("FAIL %s ACC=%02h expected=%02h", name, ACC, expv);
        end
    endtask

    task automatic test_multiply();
        run_mul("mul_pos",        8'h10, 8'h0C, 1'b0, 8'h18);
        run_mul("mul_neg",        8'hF0, 8'h0C, 1'b0, 8'hE8);
        run_mul("mul_pos_selimm", 8'h10, 8'h0C, 1'b1, 8'h18);
        run_mul("mul_neg_selimm", 8'hF0, 8'h0C, 1'b1, 8'hE8);
    endtask

    task automatic test_mul_overflow();
        run_mul("mul_wrap",      8'h40, 8'h20, 1'b0, 8'h00);
        run_mul("mul_trunc_pos", 8'h03, 8'h04, 1'b0, 8'h01);
        run_mul("mul_trunc_neg", 8'hFD, 8'h04, 1'b0, 8'hFE);
    endtask

    task automatic test_selects();
        load(8'h77);
        idle_inputs();
        WE = 1'b1; UseACC = 1'b0;
        step();
        checks++;
        if (ACC !== 8'h00) begin
            errors++; $display("FAIL no_select ACC=%02h expected=00", ACC);
        end
        idle_inputs();
        WE = 1'b1; SelImm = 1'b1; SelSW = 1'b1; Imm = 8'h0F; SW = 8'hF0;
        step();
        checks++;
        if (ACC !== 8'hFF) begin
            errors++; $display("FAIL multi_select ACC=%02h expected=FF", ACC);
        end
    endtask

    task automatic test_random();
        logic [7:0] m_acc;
        logic [7:0] expv;
        m_acc = ACC;
        for (int i = 0; i < 300; i++) begin
            Imm = 8'($urandom); RegData = 8'($urandom); SW = 8'($urandom);
            WE = 1'($urandom_range(0, 3) != 0);
            SelImm = 1'($urandom); SelSW = 1'($urandom); SelRegData = 1'($urandom);
            UseMul = 1'($urandom); UseACC = 1'($urandom);
            nReset = 1'($urandom_range(0, 19) != 0);
            if (!nReset)  expv = 8'h00;
            else if (WE)  expv = model_next(m_acc, UseACC, UseMul, SelImm, SelSW, SelRegData,
                                            Imm, SW, RegData);
            else          expv = m_acc;
            step();
            checks++;
            if (ACC !== expv) begin
                errors++;
                $display("FAIL random[%0d] ACC=%02h expected=%02h", i, ACC, expv);
            end
            m_acc = expv;
        end
        nReset = 1'b1;
    endtask

    initial begin
        nReset = 1'b0;
        idle_inputs();
        test_reset();
        test_load_hold();
        test_accumulate();
        test_multiply();
        test_mul_overflow();
        test_selects();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mac.md
# alu_mac

Accumulator-based arithmetic unit for the picoMips datapath. It holds the 8-bit accumulator `ACC` and updates it each enabled cycle with one of two results. The first is an add of the optionally retained accumulator and a selected operand. The second is a signed fixed-point multiply of the optionally retained accumulator by the instruction immediate, where the immediate is Q4.3 format. It is built from three combinational leaf blocks (`mul3mux`, `mul0mux`, `mult`) feeding a single registered multiply stage.

## Interface
No parameters; all widths are fixed at 8 bits.

- `Clock` input 1: single clock; all state updates on the rising edge.
- `nReset` input 1: reset; synchronous and active-low.
- `Imm` input 8: sign-extended instruction immediate; also the multiplier in multiply mode.
- `RegData` input 8: register-file read data.
- `SW` input 8: input switches.
- `WE` input 1: accumulator write enable.
- `SelSW` input 1: select `SW` as the operand.
- `SelImm` input 1: select `Imm` as the operand.
- `SelRegData` input 1: select `RegData` as the operand.
- `UseMul` input 1: multiply mode.
- `UseACC` input 1: use `ACC` as the first term; when low, the first term is 0.
- `ACC` output 8: accumulator register.

## Operation
All arithmetic is signed two's complement.

- **Operand `data` (`mul3mux`):**
  - `data = (SelImm ? Imm : 0) | (SelSW ? SW : 0) | (SelRegData ? RegData : 0)`, an AND-OR mux.
  - If `UseMul` = 1, `data` is forced to 0.
  - If no select is asserted, `data` = 0.
  - If several selects are asserted, the selected values are bitwise ORed; this case is legal but is not used by the decoder.
- **Base term (`mul0mux`):** `base = UseACC ? ACC : 0`.
- **Sum:** `a = base + data`, 8 bits, wrapping.
- **Multiplier `b`:**
  - `mult` computes the low 8 bits of `{7'b0,UseMul} * Imm`. This gives `Imm` when `UseMul` = 1 and 0 otherwise.
  - Bit 3 of the result is then ORed with `~UseMul`.
  - Net effect: `b = UseMul ? Imm : 8'h08`, where `8'h08` is 1.0 in Q4.3.
- **Result:**
  - `p` = low 11 bits of the signed product `a * b`.
  - Next `ACC` = `p[10:3]`, i.e. an arithmetic shift right by 3 truncated to 8 bits.
  - Add mode (`UseMul` = 0): `ACC` ← `base + data`, modulo 256.
  - Multiply mode (`UseMul` = 1): `ACC` ← `((UseACC ? ACC : 0) * Imm) >>> 3`, wrapping within 11 bits. The fractional bits are truncated toward −∞.
- **Overflow:** not flagged; results wrap silently.

## Timing
- The path from inputs and `ACC` to next-`ACC` is fully combinational; `ACC` updates on the same rising edge (1-cycle latency).
- `nReset` = 0 at a rising edge sets `ACC` to 0x00. Reset has priority over `WE`. Reset value of `ACC` is 0x00.
- `WE` = 0 holds `ACC` unchanged, whatever the other inputs are.
- No handshake and no multi-cycle state.
- Reset asserted between edges has no effect until the next edge.
- No simulation delays in RTL.

## Structure
- Shared package `alu_pkg`:
  - `ACC_W` = 8.
  - `FRAC_BITS` = 3.
  - `ONE_Q43` = 8'h08.
- Leaf modules, combinational, instantiated inside `alu_mac`:
  - `mul3mux`: ports `A`, `B`, `C`, `SA`, `SB`, `SC`, `Z`, `Out`.
  - `mul0mux`: ports `In`, `En`, `Out`.
  - `mult`: ports `A`, `B`, `Out`; 8×8 signed multiply returning the low 8 bits.
- The top contains only the final multiplier, the bit-3 patch and the `ACC` register.

## Test plan
- **Reset:** `ACC` = 0x5A; `nReset` = 0 with `WE` = 1 across one edge → `ACC` = 0x00. `nReset` = 0 between edges → `ACC` unchanged until the edge.
- **Load and hold:**
  - `UseACC` = 0, `SelImm` = 1, `Imm` = 0x25, `WE` = 1 → `ACC` = 0x25.
  - Then `WE` = 0 with `SW` = 0xFF, `SelSW` = 1 → `ACC` stays 0x25.
- **Accumulate with wrap:**
  - `ACC` = 0x25, `UseACC` = 1, `SelSW` = 1, `SW` = 0x10 → 0x35.
  - `ACC` = 0x7F, `SelRegData` = 1, `RegData` = 0x01 → 0x80.
  - `ACC` = 0xFF + 0x02 → 0x01.
- **Multiply positive and negative:** `UseMul` = 1, `UseACC` = 1, `Imm` = 0x0C (1.5):
  - `ACC` = 0x10 → 0x18.
  - `ACC` = 0xF0 → 0xE8.
  - `SelImm` = 1 asserted at the same time → same results, since `data` is forced to 0.
- **Multiply overflow and truncation:**
  - `ACC` = 0x40, `Imm` = 0x20 (4.0) → 0x00, since the 11-bit product wraps.
  - `ACC` = 0x03, `Imm` = 0x04 (0.5) → 0x01.
  - `ACC` = 0xFD, `Imm` = 0x04 → 0xFE.
- **No/multiple selects:**
  - `UseACC` = 0, no select → `ACC` = 0x00.
  - `SelImm` = `SelSW` = 1, `Imm` = 0x0F, `SW` = 0xF0, `UseACC` = 0 → 0xFF.
